// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use stalls, memory-wait freezes, branch flushes,
// a memory-access watchdog and saturating stall/flush statistics.
module hazard_stall_controller #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RS1,
    input  logic [4:0]       IF_ID_RS2,
    input  logic             IF_ID_UseRS2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             Branch_Taken,
    input  logic             MEM_Req,
    input  logic             MEM_Ack,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Pipe_Freeze,
    output logic             Halt,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t            state;
    logic [WAIT_W-1:0] waitCnt;
    logic              loadUse;
    logic              memWait;

    // x0 is hardwired to zero, so a load targeting it can never create a dependence.
    assign loadUse = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                     ((ID_EX_Rd == IF_ID_RS1) || (IF_ID_UseRS2 && (ID_EX_Rd == IF_ID_RS2)));
    assign memWait = MEM_Req && !MEM_Ack;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        Pipe_Freeze  = 1'b0;
        if (!rst_i) begin
            if (state == ERROR || memWait) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                Pipe_Freeze = 1'b1;
            end else if (loadUse) begin
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Bubble = 1'b1;
            end else if (Branch_Taken) begin
                IF_ID_Flush = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            waitCnt   <= '0;
            Halt      <= 1'b0;
            Stall_Cnt <= '0;
            Flush_Cnt <= '0;
        end else begin
            if (!PC_Write && (Stall_Cnt != '1))
                Stall_Cnt <= Stall_Cnt + CNT_W'(1);
            if (IF_ID_Flush && (Flush_Cnt != '1))
                Flush_Cnt <= Flush_Cnt + CNT_W'(1);

            case (state)
                RUN: begin
                    if (memWait) begin
                        state   <= MEM_WAIT;
                        waitCnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!memWait) begin
                        state   <= RUN;
                        waitCnt <= '0;
                    end else if (waitCnt == WAIT_W'(TIMEOUT)) begin
                        state <= ERROR;
                        Halt  <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                ERROR:   state <= ERROR;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios plus randomized traffic
// checked against a streak-based behavioural model.
module tb_hazard_stall_controller;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic [4:0]       IF_ID_RS1, IF_ID_RS2, ID_EX_Rd;
    logic             IF_ID_UseRS2, ID_EX_MemRead, Branch_Taken, MEM_Req, MEM_Ack;
    logic             PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze, Halt;
    logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;
    logic [4:0]       outs;

    int vectors = 0;
    int miscompares = 0;

    // Model: length of the current run of unacknowledged-request cycles, halt flag, counters.
    int mStreak, mStall, mFlush;
    bit mHalt;

    hazard_stall_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .IF_ID_RS1(IF_ID_RS1), .IF_ID_RS2(IF_ID_RS2), .IF_ID_UseRS2(IF_ID_UseRS2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd), .Branch_Taken(Branch_Taken),
        .MEM_Req(MEM_Req), .MEM_Ack(MEM_Ack),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .Pipe_Freeze(Pipe_Freeze), .Halt(Halt),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
    );

    always #5 clk = ~clk;

    assign outs = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze};

    // Expected {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze} for the current inputs.
    function automatic logic [4:0] expOut();
        logic lu;
        if (rst_i) return 5'b11000;
        lu = ID_EX_MemRead && (ID_EX_Rd != 0) &&
             ((ID_EX_Rd == IF_ID_RS1) || (IF_ID_UseRS2 && (ID_EX_Rd == IF_ID_RS2)));
        if (mHalt || (MEM_Req && !MEM_Ack)) return 5'b00001;
        if (lu) return 5'b00010;
        if (Branch_Taken) return 5'b11100;
        return 5'b11000;
    endfunction

    task automatic setIn(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                         input logic memRead, input logic [4:0] rd, input logic bt,
                         input logic req, input logic ack);
        IF_ID_RS1 = rs1; IF_ID_RS2 = rs2; IF_ID_UseRS2 = use2;
        ID_EX_MemRead = memRead; ID_EX_Rd = rd; Branch_Taken = bt;
        MEM_Req = req; MEM_Ack = ack;
    endtask

    task automatic modelReset();
        mStreak = 0; mHalt = 0; mStall = 0; mFlush = 0;
    endtask

    // Advance one clock edge and update the model; returns 1 ns after the edge.
    task automatic tick();
        logic [4:0] e;
        bit mw;
        e  = expOut();
        mw = MEM_Req && !MEM_Ack;
        @(posedge clk);
        if (!e[4] && mStall < CNT_MAX) mStall++;
        if (e[2] && mFlush < CNT_MAX) mFlush++;
        if (!mHalt) begin
            if (mw) begin
                mStreak++;
                if (mStreak > TIMEOUT) mHalt = 1;
            end else begin
                mStreak = 0;
            end
        end
        #1;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        #2;
        modelReset();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        setIn(5, 5, 1, 1, 5, 1, 1, 0);
        #1 rst_i = 1'b1;
        #6;
        vectors++;
        if (outs !== 5'b11000) begin
            miscompares++; $display("FAIL reset_outs: got %b want %b", outs, 5'b11000);
        end
        vectors++;
        if ({Halt, Stall_Cnt, Flush_Cnt} !== '0) begin
            miscompares++; $display("FAIL reset_regs: halt=%b stall=%0d flush=%0d want 0/0/0", Halt, Stall_Cnt, Flush_Cnt);
        end
        #1;
        modelReset();
        rst_i = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        setIn(7, 5, 1, 1, 5, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs !== 5'b00010 || Stall_Cnt !== CNT_W'(0)) begin
            miscompares++; $display("FAIL lu_rs2: outs=%b stall=%0d want 00010/0", outs, Stall_Cnt);
        end
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs !== 5'b11000 || Stall_Cnt !== CNT_W'(1)) begin
            miscompares++; $display("FAIL lu_release: outs=%b stall=%0d want 11000/1", outs, Stall_Cnt);
        end
        tick();
        setIn(7, 5, 0, 1, 5, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs !== 5'b11000) begin
            miscompares++; $display("FAIL lu_no_use2: got %b want 11000", outs);
        end
        tick();
        setIn(0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs !== 5'b11000) begin
            miscompares++; $display("FAIL lu_x0: got %b want 11000", outs);
        end
        tick();
        vectors++;
        if (Stall_Cnt !== CNT_W'(1)) begin
            miscompares++; $display("FAIL lu_stall_total: got %0d want 1", Stall_Cnt);
        end
    endtask

    task automatic test_lu_branch();
        doReset();
        setIn(5, 0, 0, 1, 5, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs !== 5'b00010) begin
            miscompares++; $display("FAIL lu_over_branch: got %b want 00010", outs);
        end
        tick();
        setIn(5, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs !== 5'b11100) begin
            miscompares++; $display("FAIL branch_flush: got %b want 11100", outs);
        end
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (Flush_Cnt !== CNT_W'(1) || Stall_Cnt !== CNT_W'(1)) begin
            miscompares++; $display("FAIL branch_counts: flush=%0d stall=%0d want 1/1", Flush_Cnt, Stall_Cnt);
        end
    endtask

    task automatic test_mem_freeze();
        int frz = 0;
        doReset();
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) setIn(5, 5, 1, 1, 5, 1, 1, 0);
            else        setIn(0, 0, 0, 0, 0, 0, 1, (k == 4));
            @(negedge clk);
            vectors++;
            if (outs !== ((k < 4) ? 5'b00001 : 5'b11000)) begin
                miscompares++; $display("FAIL freeze_cycle%0d: got %b want %b", k, outs, (k < 4) ? 5'b00001 : 5'b11000);
            end
            frz += int'(Pipe_Freeze);
            tick();
        end
        vectors++;
        if (frz != 3 || Stall_Cnt !== CNT_W'(3) || Flush_Cnt !== CNT_W'(0)) begin
            miscompares++; $display("FAIL freeze_total: freeze=%0d stall=%0d flush=%0d want 3/3/0", frz, Stall_Cnt, Flush_Cnt);
        end
        setIn(0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        vectors++;
        if (outs !== 5'b11000) begin
            miscompares++; $display("FAIL same_cycle_ack: got %b want 11000", outs);
        end
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (Stall_Cnt !== CNT_W'(3)) begin
            miscompares++; $display("FAIL same_cycle_stall: got %0d want 3", Stall_Cnt);
        end
    endtask

    task automatic test_timeout();
        doReset();
        setIn(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            vectors++;
            if (Halt !== 1'b0) begin
                miscompares++; $display("FAIL early_halt_cycle%0d: got %b want 0", i, Halt);
            end
            tick();
        end
        vectors++;
        if (Halt !== 1'b1 || outs !== 5'b00001) begin
            miscompares++; $display("FAIL halt_set: halt=%b outs=%b want 1/00001", Halt, outs);
        end
        setIn(0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        vectors++;
        if (outs !== 5'b00001) begin
            miscompares++; $display("FAIL late_ack_outs: got %b want 00001", outs);
        end
        tick();
        vectors++;
        if (Halt !== 1'b1 || Stall_Cnt !== CNT_W'(6)) begin
            miscompares++; $display("FAIL late_ack_halt: halt=%b stall=%0d want 1/6", Halt, Stall_Cnt);
        end
        setIn(0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        vectors++;
        if (outs !== 5'b00001) begin
            miscompares++; $display("FAIL halt_no_flush: got %b want 00001", outs);
        end
        tick();
        vectors++;
        if (Halt !== 1'b1 || Stall_Cnt !== CNT_W'(7) || Flush_Cnt !== CNT_W'(0)) begin
            miscompares++; $display("FAIL halt_counts: halt=%b stall=%0d flush=%0d want 1/7/0", Halt, Stall_Cnt, Flush_Cnt);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        setIn(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        tick();
        @(negedge clk);
        #1 rst_i = 1'b1;
        #1;
        vectors++;
        if (outs !== 5'b11000 || Halt !== 1'b0 || Stall_Cnt !== CNT_W'(0)) begin
            miscompares++; $display("FAIL reset_mid_wait: outs=%b halt=%b stall=%0d want 11000/0/0", outs, Halt, Stall_Cnt);
        end
        #1 rst_i = 1'b0;
        modelReset();
        for (int i = 1; i <= 5; i++) begin
            vectors++;
            if (Halt !== 1'b0) begin
                miscompares++; $display("FAIL fresh_wait_cycle%0d: halt=%b want 0", i, Halt);
            end
            tick();
        end
        vectors++;
        if (Halt !== 1'b1) begin
            miscompares++; $display("FAIL fresh_wait_halt: got %b want 1", Halt);
        end
        rst_i = 1'b1;
        #1;
        vectors++;
        if (Halt !== 1'b0 || PC_Write !== 1'b1 || Stall_Cnt !== CNT_W'(0) || Flush_Cnt !== CNT_W'(0)) begin
            miscompares++; $display("FAIL reset_halted: halt=%b pcw=%b stall=%0d flush=%0d want 0/1/0/0", Halt, PC_Write, Stall_Cnt, Flush_Cnt);
        end
        rst_i = 1'b0;
        modelReset();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        doReset();
        setIn(3, 0, 0, 1, 3, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            vectors++;
            if (Stall_Cnt !== CNT_W'((i < CNT_MAX) ? i : CNT_MAX)) begin
                miscompares++; $display("FAIL stall_sat_%0d: got %0d want %0d", i, Stall_Cnt, (i < CNT_MAX) ? i : CNT_MAX);
            end
        end
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [13:0] expv;
        doReset();
        for (int n = 0; n < 600; n++) begin
            setIn(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4));
            if ($urandom_range(0, 39) == 0) doReset();
            @(negedge clk);
            expv = {expOut(), mHalt, CNT_W'(mStall), CNT_W'(mFlush)};
            vectors++;
            if ({outs, Halt, Stall_Cnt, Flush_Cnt} !== expv) begin
                miscompares++;
                $display("FAIL random_%0d: outs/halt/stall/flush got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         n, outs, Halt, Stall_Cnt, Flush_Cnt, expv[13:9], expv[8], expv[7:4], expv[3:0]);
            end
            tick();
        end
    endtask

    initial begin
        modelReset();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_lu_branch();
        test_mem_freeze();
        test_timeout();
        test_async_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage core; sits beside the operand-forwarding logic.
- Resolves the hazards forwarding cannot cover: load-use dependences, multi-cycle data-memory accesses and taken-branch flushes.
- Drives the PC/pipeline-register write enables, bubble and flush controls, and keeps stall/flush statistics.
- A watchdog halts the core if a memory access never completes.

Parameters:
- TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before the core is halted (range 2..65535).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- IF_ID_RS1  in  5  rs1 of the instruction in ID.
- IF_ID_RS2  in  5  rs2 of the instruction in ID.
- IF_ID_UseRS2  in  1  ID instruction reads rs2.
- ID_EX_MemRead  in  1  EX-stage instruction is a load.
- ID_EX_Rd  in  5  rd of the EX-stage instruction.
- Branch_Taken  in  1  ID branch resolved taken.
- MEM_Req  in  1  MEM stage has an active data-memory access.
- MEM_Ack  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register write enable.
- IF_ID_Flush  out  1  IF/ID register loads a NOP.
- ID_EX_Bubble  out  1  zero the ID/EX control fields.
- Pipe_Freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- Halt  out  1  sticky watchdog halt.
- Stall_Cnt  out  CNT_W  cycles with PC_Write low, saturating.
- Flush_Cnt  out  CNT_W  cycles with IF_ID_Flush high, saturating.

Behaviour:
- Clock/reset: single clock. rst_i is asynchronous and active-high.
- Reset values:
  - state = RUN; wait counter = 0; Halt = 0; Stall_Cnt = 0; Flush_Cnt = 0.
  - Combinational outputs during reset: PC_Write = 1, IF_ID_Write = 1, all others 0.
- Control outputs are combinational from inputs and state: zero-cycle latency, so a stall takes effect in the cycle its cause is seen. Counters, state and Halt update on the clock edge.
- Hazard terms:
  - lu = ID_EX_MemRead & (ID_EX_Rd != 0) & ((ID_EX_Rd == IF_ID_RS1) | (IF_ID_UseRS2 & (ID_EX_Rd == IF_ID_RS2))).
  - mw = MEM_Req & ~MEM_Ack.
- Priority: HALT > freeze > load-use > flush.
  - Freeze (state != ERROR & mw): Pipe_Freeze = 1, PC_Write = 0, IF_ID_Write = 0; ID_EX_Bubble = 0 and IF_ID_Flush = 0 even if lu or Branch_Taken. Both are re-evaluated after the freeze because the ID/EX contents are held.
  - Load-use (no freeze, lu): PC_Write = 0, IF_ID_Write = 0, ID_EX_Bubble = 1, IF_ID_Flush = 0. A branch depending on the load is delayed, not flushed.
  - Flush (no freeze, no lu, Branch_Taken): IF_ID_Flush = 1; PC_Write = 1, IF_ID_Write = 1.
  - Otherwise: PC_Write = 1, IF_ID_Write = 1, others 0.
- FSM:
  - RUN: if mw, go to MEM_WAIT with wait counter = 1; else stay.
  - MEM_WAIT:
    - MEM_Ack = 1 or MEM_Req = 0: go to RUN, clear counter. The freeze releases in that same cycle, so a one-cycle ack produces zero freeze cycles.
    - Otherwise, if counter == TIMEOUT: go to ERROR, set Halt.
    - Otherwise: counter += 1.
  - ERROR: PC_Write = 0, IF_ID_Write = 0, Pipe_Freeze = 1, bubble/flush = 0; MEM_Ack is ignored. Exit only by reset.
- Freeze cycle count: an access acked in cycle k of waiting (k = 1 is the request cycle) freezes for exactly k-1 cycles; a same-cycle ack freezes for 0 cycles.
- Counters:
  - Stall_Cnt += 1 each cycle with PC_Write = 0, including in ERROR.
  - Flush_Cnt += 1 each cycle with IF_ID_Flush = 1.
  - Both saturate at all-ones and never wrap.
- Reset mid-access: the asynchronous reset forces RUN immediately, even mid-wait, and clears Halt and the counters without a clock edge.
- Register x0 never causes a load-use stall.

Test Plan:
- Load to x5 in EX (ID_EX_MemRead = 1, ID_EX_Rd = 5), IF_ID_RS2 = 5, IF_ID_UseRS2 = 1 -> one cycle of PC_Write = 0, IF_ID_Write = 0, ID_EX_Bubble = 1; Stall_Cnt goes 0 -> 1. Repeat with IF_ID_UseRS2 = 0 -> no stall. Repeat with Rd = 0 -> no stall.
- Load-use and Branch_Taken in the same cycle -> ID_EX_Bubble = 1, IF_ID_Flush = 0. Next cycle (load moved on, Branch_Taken still 1) -> IF_ID_Flush = 1; Flush_Cnt = 1.
- MEM_Req held high, MEM_Ack pulsed in the 4th request cycle -> Pipe_Freeze high for exactly 3 cycles and low in the ack cycle; Stall_Cnt = 3; state returns to RUN. MEM_Req with same-cycle ack -> 0 freeze cycles.
- MEM_Req held high with no ack, TIMEOUT = 4 -> Halt = 1 after 5 cycles and stays 1 after a late MEM_Ack; PC_Write stays 0; Stall_Cnt keeps incrementing.
- Assert rst_i between clock edges while in MEM_WAIT and while halted -> Halt = 0, counters = 0, PC_Write = 1 immediately; the next MEM_Req starts a fresh wait count.
- CNT_W = 4 with 20 consecutive stall cycles -> Stall_Cnt saturates at 15 and does not wrap.
